// File: rtl/sse_pair_sequencer.sv
// sse_pair_sequencer: initiator side of the SSE sample interface.
// A host fills a small (A,B) pair buffer, pulses start, and the block resets
// the SSE core, streams the pairs one per sse_next, marks the last one with
// sse_stop and captures Y when sse_ready rises. A watchdog aborts a stalled run.
module sse_pair_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [31:0]                wr_a,
    input  logic [31:0]                wr_b,
    input  logic                       clear,
    input  logic                       start,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy,
    output logic                       sse_rst,
    output logic [31:0]                sse_a,
    output logic [31:0]                sse_b,
    output logic                       sse_stop,
    input  logic                       sse_next,
    input  logic                       sse_ready,
    input  logic [31:0]                sse_y,
    output logic [31:0]                result,
    output logic                       result_valid,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        STREAM   = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    state_t        state;
    pair_t         mem [DEPTH];
    pair_t         rd_pair;
    logic [CW-1:0] rd_ptr;
    logic [WW-1:0] wd;
    logic          idle;
    logic          wr_ok;
    logic          wd_expired;

    assign idle       = (state == IDLE);
    // clear has priority over a same-cycle write; writes only land when idle
    assign wr_ok      = idle && wr_en && !clear && !full;
    assign rd_pair    = mem[rd_ptr[AW-1:0]];
    assign wd_expired = (wd == WW'(TIMEOUT - 1));

    // Pair storage: no reset, contents are meaningless once count is zero
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[count[AW-1:0]] <= '{a: wr_a, b: wr_b};
    end

    // Fill level, full flag and sticky overflow; all host-side edits need IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (idle) begin
            if (clear) begin
                count    <= '0;
                full     <= 1'b0;
                overflow <= 1'b0;
            end else if (wr_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                    full  <= (count == CW'(DEPTH - 1));
                end
            end
        end
    end

    // Run sequencer: core reset, pair streaming, result wait and watchdog abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sse_rst      <= 1'b1;
            sse_a        <= '0;
            sse_b        <= '0;
            sse_stop     <= 1'b0;
            rd_ptr       <= '0;
            wd           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sse_rst <= 1'b0;
                    if (start && count != '0) begin
                        state    <= CORE_RST;
                        busy     <= 1'b1;
                        sse_rst  <= 1'b1;
                        sse_a    <= mem[0].a;
                        sse_b    <= mem[0].b;
                        sse_stop <= (count == CW'(1));
                        rd_ptr   <= CW'(1);
                        timeout  <= 1'b0;
                    end
                end

                // single-cycle core reset; pair[0] is already presented
                CORE_RST: begin
                    sse_rst <= 1'b0;
                    wd      <= '0;
                    state   <= STREAM;
                end

                // sse_ready is deliberately not looked at here
                STREAM: begin
                    if (sse_next) begin
                        wd <= '0;
                        if (rd_ptr < count) begin
                            sse_a    <= rd_pair.a;
                            sse_b    <= rd_pair.b;
                            sse_stop <= (rd_ptr == count - CW'(1));
                            rd_ptr   <= rd_ptr + CW'(1);
                        end else begin
                            // last pair consumed; sse_stop stays high
                            state <= WAIT_RES;
                        end
                    end else if (wd_expired) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                        sse_stop <= 1'b0;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end

                // ready beats a simultaneous next
                WAIT_RES: begin
                    if (sse_ready) begin
                        result       <= sse_y;
                        result_valid <= 1'b1;
                        sse_stop     <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (sse_next) begin
                        wd <= '0;
                    end else if (wd_expired) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                        sse_stop <= 1'b0;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sse_pair_sequencer.sv
// Bench for sse_pair_sequencer: table of buffer vectors, then scripted runs
// against a small SSE responder with an expected-pair scoreboard queue.
module tb_sse_pair_sequencer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    typedef struct {
        logic        wr_en;
        logic [31:0] a;
        logic [31:0] b;
        logic        clear;
        logic        start;
        int          exp_count;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, clear, start;
    logic [31:0] wr_a, wr_b;
    logic [$clog2(DEPTH):0] count;
    logic        full, busy, sse_rst, sse_stop;
    logic [31:0] sse_a, sse_b, sse_y, result;
    logic        sse_next, sse_ready, result_valid, overflow, timeout;

    int    n_chk  = 0;
    int    n_fail = 0;
    pair_t exp_q[$];
    vec_t  vecs[$];
    pair_t P [3];

    sse_pair_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .clear(clear), .start(start), .count(count), .full(full), .busy(busy),
        .sse_rst(sse_rst), .sse_a(sse_a), .sse_b(sse_b), .sse_stop(sse_stop),
        .sse_next(sse_next), .sse_ready(sse_ready), .sse_y(sse_y),
        .result(result), .result_valid(result_valid), .overflow(overflow),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input pair_t p);
        wr_en = 1'b1; wr_a = p.a; wr_b = p.b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Start a run and act as the SSE core; expected pairs come from exp_q
    task automatic run(input int n, input logic [31:0] y);
        pair_t e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sse_rst_hi", sse_rst, 1);
        chk("busy_run", busy, 1);
        chk("first_a_latency", sse_a, exp_q[0].a);
        chk("first_stop", sse_stop, (n == 1));
        @(negedge clk);
        chk("sse_rst_lo", sse_rst, 0);
        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                sse_ready = 1'b1;
                sse_y     = 32'hDEADBEEF;
            end
            repeat (i % 3) @(negedge clk);
            sse_ready = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("pair%0d_a", i), sse_a, e.a);
            chk($sformatf("pair%0d_b", i), sse_b, e.b);
            chk($sformatf("pair%0d_stop", i), sse_stop, (i == n - 1));
            sse_next = 1'b1;
            @(negedge clk);
            sse_next = 1'b0;
        end
        chk("wait_stop", sse_stop, 1);
        chk("wait_busy", busy, 1);
        chk("no_early_rv", result_valid, 0);
        @(negedge clk);
        sse_ready = 1'b1; sse_next = 1'b1; sse_y = y;
        @(negedge clk);
        sse_ready = 1'b0; sse_next = 1'b0; sse_y = '0;
        chk("rv_pulse", result_valid, 1);
        chk("result", result, y);
        chk("stop_cleared", sse_stop, 0);
        chk("busy_done", busy, 0);
        @(negedge clk);
        chk("rv_single", result_valid, 0);
        chk("result_hold", result, y);
    endtask

    // Count cycles until busy drops, bounded
    task automatic wait_idle(output int cyc, output logic rv_seen);
        cyc = 0; rv_seen = 1'b0;
        while (busy && cyc < 50) begin
            cyc++;
            if (result_valid) rv_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   cyc;
        logic rvs;
        pair_t e;
        vec_t v;

        P[0] = '{a: 32'h40800000, b: 32'h40000000};
        P[1] = '{a: 32'h41000000, b: 32'h40800000};
        P[2] = '{a: 32'h41800000, b: 32'h41000000};

        for (int k = 0; k < 17; k++) begin
            v = '{wr_en: 1'b1, a: 32'h1000 + k, b: 32'h2000 + k, clear: 1'b0, start: 1'b0,
                  exp_count: (k < 16) ? k + 1 : 16, exp_full: (k >= 15),
                  exp_ovf: (k == 16), exp_busy: 1'b0};
            vecs.push_back(v);
        end
        // clear together with a write: clear wins
        vecs.push_back('{wr_en: 1'b1, a: 32'h5, b: 32'h6, clear: 1'b1, start: 1'b0,
                         exp_count: 0, exp_full: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0});
        vecs.push_back('{wr_en: 1'b0, a: 32'h0, b: 32'h0, clear: 1'b0, start: 1'b1,
                         exp_count: 0, exp_full: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0});

        rst = 1'b1; wr_en = 0; wr_a = 0; wr_b = 0; clear = 0; start = 0;
        sse_next = 0; sse_ready = 0; sse_y = 0;
        repeat (2) @(negedge clk);
        chk("rst_sse_rst", sse_rst, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_sse_rst", sse_rst, 0);

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_a = vecs[i].a; wr_b = vecs[i].b;
            clear = vecs[i].clear; start = vecs[i].start;
            @(negedge clk);
            wr_en = 0; clear = 0; start = 0;
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // three-pair run, then replay without rewriting
        for (int i = 0; i < 3; i++) load(P[i]);
        chk("count3", count, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(P[i]);
        run(3, 32'h42A80000);
        for (int i = 0; i < 3; i++) exp_q.push_back(P[i]);
        run(3, 32'h42A80000);
        chk("q_empty", exp_q.size(), 0);

        // single pair
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        load(P[0]);
        exp_q.push_back(P[0]);
        run(1, 32'h40800000);

        // watchdog: responder stays silent
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle(cyc, rvs);
        chk("to_busy_cycles", cyc, TIMEOUT + 1);
        chk("to_flag", timeout, 1);
        chk("to_no_rv", rvs, 0);
        chk("to_result_kept", result, 32'h40800000);
        chk("to_stop_low", sse_stop, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("to_cleared_by_start", timeout, 0);
        chk("to_rerun_busy", busy, 1);
        wait_idle(cyc, rvs);
        chk("to_again", timeout, 1);

        // reset in the middle of streaming
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        for (int i = 0; i < 3; i++) load(P[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(P[i]);
        start = 1'b1; @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("mid%0d_a", i), sse_a, e.a);
            sse_next = 1'b1; @(negedge clk); sse_next = 1'b0;
        end
        chk("mid_pair2_a", sse_a, P[2].a);
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("mr_sse_a", sse_a, 0);
        chk("mr_sse_b", sse_b, 0);
        chk("mr_stop", sse_stop, 0);
        chk("mr_busy", busy, 0);
        chk("mr_count", count, 0);
        chk("mr_timeout", timeout, 0);
        chk("mr_result", result, 0);
        chk("mr_sse_rst", sse_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1; wr_a = 32'hAAAA0001; wr_b = 32'hBBBB0001;
        @(negedge clk);
        wr_en = 1'b0;
        chk("post_rst_write", count, 1);
        chk("post_rst_sse_rst", sse_rst, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
